// File: rtl/axi_req_pkg.sv
// Shared types, AXI encodings and helpers for the single-beat request master.
package axi_req_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WRITE_RESP = 3'd2,
    READ_ADDR  = 3'd3,
    READ_DATA  = 3'd4,
    RESP       = 3'd5
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI size encoding is log2 of the beat width in bytes.
  function automatic logic [2:0] size_from_width(input int unsigned width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (width == (32'd8 << i)) begin
        size = 3'(i);
      end
    end
    return size;
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle carrying the channels used by a single-beat master.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_req_master.sv
// Turns a valid/ready request stream into single-beat AXI4 transactions, one in flight,
// and returns one response (read data, error flag) per request.
module axi_req_master
  import axi_req_pkg::*;
#(
  parameter int unsigned             AXI_ID_WIDTH   = 10,
  parameter int unsigned             AXI_ADDR_WIDTH = 64,
  parameter int unsigned             AXI_DATA_WIDTH = 64,
  parameter int unsigned             AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = {AXI_ID_WIDTH{1'b0}}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_be_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  AXI_BUS.Master                      axi_master_port
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  AXI_SIZE   = size_from_width(AXI_DATA_WIDTH);

  state_e                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      b_ready_q, b_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     be_q, be_d;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, req_hs_s, rsp_hs_s;

  assign aw_hs_s  = aw_valid_q  & axi_master_port.aw_ready;
  assign w_hs_s   = w_valid_q   & axi_master_port.w_ready;
  assign b_hs_s   = b_ready_q   & axi_master_port.b_valid;
  assign ar_hs_s  = ar_valid_q  & axi_master_port.ar_ready;
  assign r_hs_s   = r_ready_q   & axi_master_port.r_valid;
  assign req_hs_s = req_ready_q & req_valid_i;
  assign rsp_hs_s = rsp_valid_q & rsp_ready_i;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;

    case (state_q)
      IDLE: begin
        if (req_hs_s) begin
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          be_d        = req_be_i;
          req_ready_d = 1'b0;
          if (req_we_i) begin
            state_d    = WRITE;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = READ_ADDR;
            ar_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      // AW and W retire independently; a handshake this cycle already counts as done.
      WRITE: begin
        aw_done_d  = aw_done_q | aw_hs_s;
        w_done_d   = w_done_q | w_hs_s;
        aw_valid_d = ~aw_done_d;
        w_valid_d  = ~w_done_d;
        if (aw_done_d && w_done_d) begin
          state_d   = WRITE_RESP;
          b_ready_d = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end

      WRITE_RESP: begin
        if (b_hs_s) begin
          state_d     = RESP;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {AXI_DATA_WIDTH{1'b0}};
          rsp_err_d   = resp_is_err(axi_master_port.b_resp);
        end else begin
          state_d = WRITE_RESP;
        end
      end

      READ_ADDR: begin
        if (ar_hs_s) begin
          state_d    = READ_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end else begin
          state_d = READ_ADDR;
        end
      end

      // A single-beat read must carry r_last; a missing one is reported as an error.
      READ_DATA: begin
        if (r_hs_s) begin
          state_d     = RESP;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi_master_port.r_data;
          rsp_err_d   = resp_is_err(axi_master_port.r_resp) | ~axi_master_port.r_last;
        end else begin
          state_d = READ_DATA;
        end
      end

      RESP: begin
        if (rsp_hs_s) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        aw_valid_d  = 1'b0;
        w_valid_d   = 1'b0;
        b_ready_d   = 1'b0;
        ar_valid_d  = 1'b0;
        r_ready_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset returns to IDLE with every valid low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {AXI_DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
      addr_q      <= {AXI_ADDR_WIDTH{1'b0}};
      wdata_q     <= {AXI_DATA_WIDTH{1'b0}};
      be_q        <= {STRB_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  assign axi_master_port.aw_id     = AXI_ID;
  assign axi_master_port.aw_addr   = addr_q;
  assign axi_master_port.aw_len    = 8'd0;
  assign axi_master_port.aw_size   = AXI_SIZE;
  assign axi_master_port.aw_burst  = BURST_INCR;
  assign axi_master_port.aw_lock   = 1'b0;
  assign axi_master_port.aw_cache  = 4'b0000;
  assign axi_master_port.aw_prot   = 3'b000;
  assign axi_master_port.aw_qos    = 4'b0000;
  assign axi_master_port.aw_region = 4'b0000;
  assign axi_master_port.aw_atop   = 6'b000000;
  assign axi_master_port.aw_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi_master_port.aw_valid  = aw_valid_q;

  assign axi_master_port.w_data  = wdata_q;
  assign axi_master_port.w_strb  = be_q;
  assign axi_master_port.w_last  = 1'b1;
  assign axi_master_port.w_user  = {AXI_USER_WIDTH{1'b0}};
  assign axi_master_port.w_valid = w_valid_q;

  assign axi_master_port.b_ready = b_ready_q;

  assign axi_master_port.ar_id     = AXI_ID;
  assign axi_master_port.ar_addr   = addr_q;
  assign axi_master_port.ar_len    = 8'd0;
  assign axi_master_port.ar_size   = AXI_SIZE;
  assign axi_master_port.ar_burst  = BURST_INCR;
  assign axi_master_port.ar_lock   = 1'b0;
  assign axi_master_port.ar_cache  = 4'b0000;
  assign axi_master_port.ar_prot   = 3'b000;
  assign axi_master_port.ar_qos    = 4'b0000;
  assign axi_master_port.ar_region = 4'b0000;
  assign axi_master_port.ar_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi_master_port.ar_valid  = ar_valid_q;

  assign axi_master_port.r_ready = r_ready_q;

endmodule

// File: tb/tb_axi_req_master.sv
// Bench for axi_req_master: a transaction-level model of the request/response and AXI
// handshake rules, directed scenarios with literal expectations, then randomized traffic.
module tb_axi_req_master;
  import axi_req_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 10;
  localparam int UW = 10;
  localparam int SW = DW / 8;
  localparam int NLOG = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_be;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) axi ();

  axi_req_master #(
    .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .AXI_ID(10'd0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .axi_master_port(axi)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [SW-1:0] be;
    logic [1:0]    resp;
    logic          rlast;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
  } txn_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  txn_t pend[$];
  txn_t cur;
  bit   busy, aw_todo, w_todo, ar_todo, resp_todo, rsp_pend;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  int   aw_c, w_c, b_c, ar_c, r_c, rsp_c;
  int   id = 0;
  int   n_acc = 0;

  int            acc_cyc[NLOG], awhs_cyc[NLOG], whs_cyc[NLOG], brdy_cyc[NLOG], rsp_cyc[NLOG], rsphs_cyc[NLOG];
  logic [DW-1:0] got_rdata[NLOG];
  logic          got_err[NLOG];
  logic [AW-1:0] seen_awaddr[NLOG], seen_araddr[NLOG];
  logic [DW-1:0] seen_wdata[NLOG];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [SW-1:0] be, input logic [1:0] resp, input logic [DW-1:0] rdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.resp = resp; t.rdata = rdata;
    t.rlast = 1'b1;
    t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = 0; t.r_dly = 0; t.rsp_dly = 0;
    return t;
  endfunction

  task automatic drive_idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    axi.r_valid = 1'b0; axi.r_resp = 2'b00; axi.r_last = 1'b0; axi.r_data = '0;
  endtask

  task automatic model_clear();
    busy = 0; aw_todo = 0; w_todo = 0; ar_todo = 0; resp_todo = 0; rsp_pend = 0;
    pend.delete();
  endtask

  // One bench cycle at the falling edge: check outputs, drive slave/requester, advance the model.
  task automatic step();
    bit e_awv, e_wv, e_br, e_arv, e_rr;
    bit req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
    @(negedge clk);
    cyc++;
    e_awv = busy && cur.we && aw_todo;
    e_wv  = busy && cur.we && w_todo;
    e_br  = busy && cur.we && !aw_todo && !w_todo && resp_todo;
    e_arv = busy && !cur.we && ar_todo;
    e_rr  = busy && !cur.we && !ar_todo && resp_todo;
    chk("req_ready", req_ready, !busy);
    chk("aw_valid", axi.aw_valid, e_awv);
    chk("w_valid", axi.w_valid, e_wv);
    chk("b_ready", axi.b_ready, e_br);
    chk("ar_valid", axi.ar_valid, e_arv);
    chk("r_ready", axi.r_ready, e_rr);
    chk("rsp_valid", rsp_valid, rsp_pend);
    if (e_awv) chk("aw_addr", axi.aw_addr, cur.addr);
    if (e_wv) begin
      chk("w_data", axi.w_data, cur.wdata);
      chk("w_strb", axi.w_strb, cur.be);
      chk("w_last", axi.w_last, 1);
    end
    if (e_arv) chk("ar_addr", axi.ar_addr, cur.addr);
    if (rsp_pend) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", rsp_err, exp_err);
    end
    if (id < NLOG) begin
      if (axi.b_ready === 1'b1 && brdy_cyc[id] < 0) brdy_cyc[id] = cyc;
      if (rsp_valid === 1'b1 && rsp_cyc[id] < 0) rsp_cyc[id] = cyc;
    end

    req_valid = (pend.size() > 0);
    if (req_valid) begin
      req_we = pend[0].we; req_addr = pend[0].addr; req_wdata = pend[0].wdata; req_be = pend[0].be;
    end else begin
      req_we = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      req_be = 8'($urandom);
    end
    axi.aw_ready = (aw_c == 0);
    if (axi.aw_valid && aw_c > 0) aw_c--;
    axi.w_ready = (w_c == 0);
    if (axi.w_valid && w_c > 0) w_c--;
    axi.ar_ready = (ar_c == 0);
    if (axi.ar_valid && ar_c > 0) ar_c--;
    axi.b_valid = 1'b0; axi.b_resp = 2'($urandom);
    if (e_br) begin
      if (b_c == 0) begin axi.b_valid = 1'b1; axi.b_resp = cur.resp; end
      else b_c--;
    end
    axi.r_valid = 1'b0; axi.r_resp = 2'($urandom); axi.r_last = 1'($urandom);
    axi.r_data = {$urandom, $urandom};
    if (e_rr) begin
      if (r_c == 0) begin
        axi.r_valid = 1'b1; axi.r_resp = cur.resp; axi.r_last = cur.rlast; axi.r_data = cur.rdata;
      end else r_c--;
    end
    rsp_ready = (rsp_c == 0);
    if (rsp_valid && rsp_c > 0) rsp_c--;

    req_hs = req_valid && req_ready;
    aw_hs  = axi.aw_valid && axi.aw_ready;
    w_hs   = axi.w_valid && axi.w_ready;
    b_hs   = axi.b_valid && axi.b_ready;
    ar_hs  = axi.ar_valid && axi.ar_ready;
    r_hs   = axi.r_valid && axi.r_ready;
    rsp_hs = rsp_valid && rsp_ready;

    if (aw_hs) begin aw_todo = 0; if (id < NLOG) begin awhs_cyc[id] = cyc; seen_awaddr[id] = axi.aw_addr; end end
    if (w_hs) begin w_todo = 0; if (id < NLOG) begin whs_cyc[id] = cyc; seen_wdata[id] = axi.w_data; end end
    if (ar_hs) begin ar_todo = 0; if (id < NLOG) seen_araddr[id] = axi.ar_addr; end
    if (b_hs) begin resp_todo = 0; rsp_pend = 1; exp_rdata = '0; exp_err = cur.resp[1]; end
    if (r_hs) begin resp_todo = 0; rsp_pend = 1; exp_rdata = cur.rdata; exp_err = cur.resp[1] | ~cur.rlast; end
    if (rsp_hs) begin
      rsp_pend = 0; busy = 0;
      if (id < NLOG) begin rsphs_cyc[id] = cyc; got_rdata[id] = rsp_rdata; got_err[id] = rsp_err; end
    end
    if (req_hs && pend.size() > 0) begin
      cur = pend.pop_front();
      id = n_acc; n_acc++;
      busy = 1; aw_todo = cur.we; w_todo = cur.we; ar_todo = !cur.we; resp_todo = 1;
      aw_c = cur.aw_dly; w_c = cur.w_dly; b_c = cur.b_dly; ar_c = cur.ar_dly; r_c = cur.r_dly;
      rsp_c = cur.rsp_dly;
      if (id < NLOG) begin
        acc_cyc[id] = cyc; awhs_cyc[id] = -1; whs_cyc[id] = -1; brdy_cyc[id] = -1;
        rsp_cyc[id] = -1; rsphs_cyc[id] = -1;
      end
    end
  endtask

  task automatic run(input string nm, input int budget);
    int n = 0;
    while ((pend.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (pend.size() > 0 || busy) begin
      bad++;
      $display("FAIL %s timeout: %0d requests left, busy=%0d after %0d cycles", nm, pend.size(), busy, budget);
    end
  endtask

  initial begin
    txn_t t;
    int a, b;
    for (int i = 0; i < NLOG; i++) begin
      acc_cyc[i] = -1; awhs_cyc[i] = -1; whs_cyc[i] = -1; brdy_cyc[i] = -1; rsp_cyc[i] = -1; rsphs_cyc[i] = -1;
    end
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; rsp_c = 0;
    model_clear();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, rsp_valid}, 0);
    chk("reset rsp", {rsp_rdata, rsp_err}, 0);
    chk("reset latched addr", axi.aw_addr, 0);
    chk("reset latched data", {axi.w_data, axi.w_strb}, 0);
    chk("const aw", {axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst}, {10'd0, 8'd0, 3'd3, 2'b01});
    chk("const ar", {axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst}, {10'd0, 8'd0, 3'd3, 2'b01});
    chk("const aw misc", {axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region, axi.aw_atop, axi.aw_user}, 0);
    chk("const ar misc", {axi.ar_lock, axi.ar_cache, axi.ar_prot, axi.ar_qos, axi.ar_region, axi.ar_user}, 0);
    chk("const w", {axi.w_last, axi.w_user}, {1'b1, 10'd0});
    #1 rst_n = 1'b1;
    repeat (2) step();

    // Write to an always-ready slave.
    pend.push_back(mk(1'b1, 64'h5000_0000, 64'hdead_beef_1234_5678, 8'hFF, RESP_OKAY, 64'd0));
    run("write basic", 40);
    chk("wr aw at cycle 1", awhs_cyc[0] - acc_cyc[0], 1);
    chk("wr aw_addr", seen_awaddr[0], 64'h5000_0000);
    chk("wr w_data", seen_wdata[0], 64'hdead_beef_1234_5678);
    chk("wr rsp at cycle 3", rsp_cyc[0] - acc_cyc[0], 3);
    chk("wr rsp err/rdata", {got_err[0], got_rdata[0]}, 0);

    // Write with AW held off three cycles.
    t = mk(1'b1, 64'h5000_0010, 64'h1111_2222_3333_4444, 8'h0F, RESP_OKAY, 64'd0);
    t.aw_dly = 3;
    pend.push_back(t);
    run("write aw delay", 40);
    chk("awdly w hs cycle", whs_cyc[1] - acc_cyc[1], 1);
    chk("awdly aw hs cycle", awhs_cyc[1] - acc_cyc[1], 4);
    chk("awdly b_ready cycle", brdy_cyc[1] - acc_cyc[1], 5);
    chk("awdly rsp cycle", rsp_cyc[1] - acc_cyc[1], 6);
    chk("awdly err", got_err[1], 0);

    // Reads: OKAY then DECERR, then a SLVERR write.
    pend.push_back(mk(1'b0, 64'h5000_0008, 64'd0, 8'h00, RESP_OKAY, 64'h0123_4567_89ab_cdef));
    pend.push_back(mk(1'b0, 64'h5000_0018, 64'd0, 8'h00, RESP_DECERR, 64'h5555_aaaa_5555_aaaa));
    pend.push_back(mk(1'b1, 64'h5000_0020, 64'h0f0f_0f0f_0f0f_0f0f, 8'h3C, RESP_SLVERR, 64'd0));
    run("errors", 80);
    chk("rd ar_addr", seen_araddr[2], 64'h5000_0008);
    chk("rd rdata", got_rdata[2], 64'h0123_4567_89ab_cdef);
    chk("rd err", got_err[2], 0);
    chk("rd rsp at cycle 3", rsp_cyc[2] - acc_cyc[2], 3);
    chk("rd decerr", got_err[3], 1);
    chk("wr slverr", {got_err[4], got_rdata[4]}, {1'b1, 64'd0});

    // Response back-pressure with a second request already waiting.
    t = mk(1'b0, 64'h5000_0028, 64'd0, 8'h00, RESP_OKAY, 64'hfeed_face_cafe_f00d);
    t.rsp_dly = 5;
    pend.push_back(t);
    pend.push_back(mk(1'b1, 64'h5000_0030, 64'h0000_0000_0000_00aa, 8'h01, RESP_OKAY, 64'd0));
    run("backpressure", 60);
    a = 5; b = 6;
    chk("bp hold cycles", rsphs_cyc[a] - rsp_cyc[a], 5);
    chk("bp rdata", got_rdata[a], 64'hfeed_face_cafe_f00d);
    chk("bp next accept", acc_cyc[b] - rsphs_cyc[a], 1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      t = mk(1'($urandom), {$urandom, $urandom} & ~64'h7, {$urandom, $urandom}, 8'($urandom),
             2'($urandom), {$urandom, $urandom});
      t.rlast = ($urandom_range(0, 9) != 0);
      t.aw_dly = $urandom_range(0, 3); t.w_dly = $urandom_range(0, 3); t.b_dly = $urandom_range(0, 2);
      t.ar_dly = $urandom_range(0, 3); t.r_dly = $urandom_range(0, 3); t.rsp_dly = $urandom_range(0, 2);
      pend.push_back(t);
    end
    run("random", 2000);

    // Asynchronous reset in the middle of a write.
    t = mk(1'b1, 64'h5000_0040, 64'h7777_7777_7777_7777, 8'hFF, RESP_OKAY, 64'd0);
    t.aw_dly = 20; t.w_dly = 20;
    pend.push_back(t);
    a = 0;
    while (axi.aw_valid !== 1'b1 && a < 10) begin step(); a++; end
    chk("mid-reset aw_valid seen", axi.aw_valid, 1);
    #1 rst_n = 1'b0;
    #1 chk("async reset valids", {axi.aw_valid, axi.w_valid, rsp_valid}, 0);
    model_clear();
    drive_idle();
    @(negedge clk);
    #1 rst_n = 1'b1;
    #2 chk("req_ready after reset", req_ready, 1);
    step();
    pend.push_back(mk(1'b0, 64'h5000_0048, 64'd0, 8'h00, RESP_OKAY, 64'h0bad_c0de_0000_0001));
    run("after reset", 40);
    chk("after reset rdata", got_rdata[n_acc - 1], 64'h0bad_c0de_0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
